// File: rtl/aw_row_collector_if.sv
// Row output stream from the AW row collector to the write-back DMA.
// The master drives the packed row and its qualifiers; the slave returns ready.
interface aw_row_collector_if #(
  parameter int ARRAY_WIDTH = 16,
  parameter int QSIZE       = 8
);
  logic [ARRAY_WIDTH*QSIZE-1:0] row_data;
  logic                         row_valid;
  logic                         row_ready;
  logic                         row_last;

  modport master (
    output row_data,
    output row_valid,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_valid,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/aw_row_collector.sv
// AW row collector: deskews per-column AW element streams through one FIFO
// per column and emits one packed row word per popped set of column heads.
// Rows are counted per tile; the final row is flagged and completion pulses done.
module aw_row_collector #(
  parameter int ARRAY_WIDTH = 16,
  parameter int QSIZE       = 8,
  parameter int DEPTH       = 32,
  parameter int ROWW        = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [QSIZE-1:0]         aw_cb_data  [0:ARRAY_WIDTH-1],
  input  logic                     aw_cb_valid [0:ARRAY_WIDTH-1],
  input  logic                     i_start,
  input  logic [ROWW-1:0]          i_tile_rows,
  input  logic                     i_clear_overflow,
  aw_row_collector_if.master       o_row,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_fifo_level_max
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              RDW      = ARRAY_WIDTH * QSIZE;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [ROWW-1:0] ONE_ROW  = ROWW'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [ROWW-1:0]   r_rows_left;
  logic              r_last_loaded;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic              r_row_valid;
  logic              r_row_last;
  logic [RDW-1:0]    r_row_data;

  logic [AW:0]       w_cnt  [ARRAY_WIDTH];
  logic [QSIZE-1:0]  w_head [ARRAY_WIDTH];
  logic              w_drop [ARRAY_WIDTH];
  logic              w_allne;
  logic              w_any_drop;
  logic              w_load;
  logic              w_accept;
  logic [RDW-1:0]    w_row_next;
  logic [AW:0]       w_lvl_max;

  // A row may load only while a tile is running and its last row is not yet out,
  // and only when the output register is free or is being drained this cycle.
  assign w_accept = r_row_valid && o_row.row_ready;
  assign w_load   = (r_state == S_RUN) && !r_last_loaded && w_allne &&
                    (!r_row_valid || o_row.row_ready);

  for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
    logic [QSIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_full;
    logic             w_push;

    // A full FIFO still takes a push when the same cycle pops its head.
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_push    = aw_cb_valid[c] && (!w_full || w_load);
    assign w_drop[c] = aw_cb_valid[c] && w_full && !w_load;
    assign w_cnt[c]  = r_cnt;
    assign w_head[c] = r_mem[r_rptr];

    // Column element storage; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= aw_cb_data[c];
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_load) r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_load)      r_cnt <= r_cnt + 1'b1;
        else if (!w_push && w_load) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Gather column heads into the next row word, the all-non-empty flag and the max level.
  always_comb begin
    w_allne    = 1'b1;
    w_lvl_max  = '0;
    w_row_next = '0;
    for (int c = 0; c < ARRAY_WIDTH; c++) begin
      if (w_cnt[c] == '0)        w_allne   = 1'b0;
      if (w_cnt[c] > w_lvl_max)  w_lvl_max = w_cnt[c];
      w_row_next[c*QSIZE +: QSIZE] = w_head[c];
    end
  end

  // Any column losing an element this cycle.
  always_comb begin
    w_any_drop = 1'b0;
    for (int c = 0; c < ARRAY_WIDTH; c++) begin
      if (w_drop[c]) w_any_drop = 1'b1;
    end
  end

  // Tile FSM together with the registered row output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_rows_left   <= '0;
      r_last_loaded <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_row_valid   <= 1'b0;
      r_row_last    <= 1'b0;
      r_row_data    <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_row_data  <= w_row_next;
        r_row_valid <= 1'b1;
        r_row_last  <= (r_rows_left == ONE_ROW);
        r_rows_left <= r_rows_left - 1'b1;
        if (r_rows_left == ONE_ROW) r_last_loaded <= 1'b1;
      end else if (w_accept) begin
        r_row_valid <= 1'b0;
        r_row_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rows_left   <= i_tile_rows;
            r_last_loaded <= 1'b0;
            if (i_tile_rows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept && r_row_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 r_overflow <= 1'b0;
    else if (w_any_drop)       r_overflow <= 1'b1;
    else if (i_clear_overflow) r_overflow <= 1'b0;
  end

  assign o_row.row_data  = r_row_data;
  assign o_row.row_valid = r_row_valid;
  assign o_row.row_last  = r_row_last;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_overflow      = r_overflow;
  assign o_fifo_level_max = w_lvl_max;

endmodule

// File: tb/tb_aw_row_collector.sv
// Bench for aw_row_collector: directed scenarios plus randomized tiles.
// Pushed column elements go into per-column queues; the monitor forms the
// expected row from the oldest element of every column at each accepted row.
module tb_aw_row_collector;
  localparam int AWID = 4;
  localparam int QS   = 8;
  localparam int DEP  = 4;
  localparam int RW   = 8;
  localparam int LW   = $clog2(DEP) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [QS-1:0]    aw_cb_data  [0:AWID-1];
  logic             aw_cb_valid [0:AWID-1];
  logic             i_start;
  logic [RW-1:0]    i_tile_rows;
  logic             i_clear_overflow;
  logic             o_busy;
  logic             o_done;
  logic             o_overflow;
  logic [LW-1:0]    o_fifo_level_max;

  aw_row_collector_if #(.ARRAY_WIDTH(AWID), .QSIZE(QS)) row_if ();

  aw_row_collector #(.ARRAY_WIDTH(AWID), .QSIZE(QS), .DEPTH(DEP), .ROWW(RW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .aw_cb_data       (aw_cb_data),
    .aw_cb_valid      (aw_cb_valid),
    .i_start          (i_start),
    .i_tile_rows      (i_tile_rows),
    .i_clear_overflow (i_clear_overflow),
    .o_row            (row_if),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_overflow       (o_overflow),
    .o_fifo_level_max (o_fifo_level_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-column queues of elements the collector must retain.
  logic [QS-1:0] colq [AWID][$];
  int  m_tile_rows = 0;
  int  tile_acc    = 0;
  int  rows_total  = 0;
  bit  rnd_ready   = 0;
  bit  done_skip   = 0;
  bit  done_seen   = 0;

  logic        mon_pv = 0, mon_pr = 0, mon_plast = 0, mon_due = 0;
  logic [31:0] mon_pdata = '0, mon_exp = '0;
  bit          mon_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < AWID; c++) aw_cb_valid[c] = 1'b0;
    i_start          = 1'b0;
    i_clear_overflow = 1'b0;
    if (rnd_ready) row_if.row_ready = 1'($urandom % 2);
    if (o_done) done_seen = 1;
  endtask

  task automatic push(input int c, input logic [QS-1:0] d, input bit keep_full);
    aw_cb_valid[c] = 1'b1;
    aw_cb_data[c]  = d;
    if (colq[c].size() < DEP || keep_full) colq[c].push_back(d);
  endtask

  task automatic start_tile(input int r);
    i_start     = 1'b1;
    i_tile_rows = RW'(r);
    m_tile_rows = r;
    tile_acc    = 0;
    done_seen   = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(done_seen), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    64'(row_if.row_valid), 64'(0));
    chk({tag, "_last"},     64'(row_if.row_last),  64'(0));
    chk({tag, "_busy"},     64'(o_busy),           64'(0));
    chk({tag, "_done"},     64'(o_done),           64'(0));
    chk({tag, "_overflow"}, 64'(o_overflow),       64'(0));
    chk({tag, "_data"},     64'(row_if.row_data),  64'(0));
    chk({tag, "_level"},    64'(o_fifo_level_max), 64'(0));
  endtask

  // Monitor: output hold rule, done pulse timing and row content at every accept.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_pv  = 0;
      mon_due = 0;
    end else begin
      if (mon_pv && !mon_pr) begin
        chk("hold_valid", 64'(row_if.row_valid), 64'(1));
        chk("hold_data",  64'(row_if.row_data),  64'(mon_pdata));
        chk("hold_last",  64'(row_if.row_last),  64'(mon_plast));
      end
      if (!done_skip && (mon_due || o_done))
        chk("done_pulse", 64'(o_done), 64'(mon_due));
      mon_due = 0;
      if (row_if.row_valid && row_if.row_ready) begin
        mon_ok  = 1;
        mon_exp = '0;
        for (int c = 0; c < AWID; c++) begin
          if (colq[c].size() == 0) mon_ok = 0;
          else mon_exp[c*QS +: QS] = colq[c][0];
        end
        if (!mon_ok) begin
          chk("row_available", 64'(0), 64'(1));
        end else begin
          for (int c = 0; c < AWID; c++) void'(colq[c].pop_front());
          chk("row_data", 64'(row_if.row_data), 64'(mon_exp));
        end
        chk("row_last", 64'(row_if.row_last), 64'(tile_acc == m_tile_rows - 1));
        if (row_if.row_last) mon_due = 1;
        tile_acc++;
        rows_total++;
      end
      mon_pv    = row_if.row_valid;
      mon_pr    = row_if.row_ready;
      mon_pdata = row_if.row_data;
      mon_plast = row_if.row_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  q [AWID];
    int  r, maxsz, n, rt0;
    bit  pend;
    bit  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int c = 0; c < AWID; c++) begin
      aw_cb_valid[c] = 1'b0;
      aw_cb_data[c]  = '0;
    end
    i_start = 0; i_tile_rows = '0; i_clear_overflow = 0;
    row_if.row_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rstn = 1'b1;

    // Aligned columns, tile of 4, ready high
    tick(); start_tile(4);
    tick(); chk("aligned_busy", 64'(o_busy), 64'(1));
    for (int c = 0; c < AWID; c++) push(c, 8'(c*16 + 0), 0);
    tick(); chk("aligned_lat_early", 64'(row_if.row_valid), 64'(0));
    for (int c = 0; c < AWID; c++) push(c, 8'(c*16 + 1), 0);
    i_start = 1'b1; i_tile_rows = RW'(7);
    tick(); chk("aligned_row0_valid", 64'(row_if.row_valid), 64'(1));
    chk("aligned_row0_data", 64'(row_if.row_data), 64'h30201000);
    for (int c = 0; c < AWID; c++) push(c, 8'(c*16 + 2), 0);
    tick();
    for (int c = 0; c < AWID; c++) push(c, 8'(c*16 + 3), 0);
    tick();
    chk("aligned_row2_valid", 64'(row_if.row_valid), 64'(1));
    tick();
    chk("aligned_row3_last", 64'(row_if.row_last), 64'(1));
    tick();
    chk("aligned_done", 64'(o_done), 64'(1));
    chk("aligned_idle", 64'(o_busy), 64'(0));
    chk("aligned_valid_drop", 64'(row_if.row_valid), 64'(0));
    chk("aligned_no_ovf", 64'(o_overflow), 64'(0));

    // Skewed columns: column c starts c cycles late
    tick(); start_tile(3);
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 3 || t == 4) chk("skew_wait_col3", 64'(row_if.row_valid), 64'(0));
      if (t == 5)           chk("skew_row0_valid", 64'(row_if.row_valid), 64'(1));
      for (int c = 0; c < AWID; c++)
        if (t - c >= 0 && t - c < 3) push(c, 8'(c*16 + (t - c)), 0);
    end
    wait_done("skew_done", 40);

    // Backpressure with ready pattern 1,0,0,1
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int c = 0; c < AWID; c++) push(c, 8'($urandom), 0);
    end
    rt0 = rows_total;
    tick(); start_tile(4);
    n = 0;
    while (!done_seen && n < 60) begin
      tick();
      row_if.row_ready = pat[n % 4];
      n++;
    end
    chk("bp_done", 64'(done_seen), 64'(1));
    chk("bp_rows", 64'(rows_total - rt0), 64'(4));
    row_if.row_ready = 1'b1;

    // Overflow on column 0 while idle
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) chk("ovf_before", 64'(o_overflow), 64'(0));
      push(0, 8'(8'hA0 + k), 0);
    end
    tick();
    chk("ovf_set", 64'(o_overflow), 64'(1));
    chk("ovf_level", 64'(o_fifo_level_max), 64'(DEP));
    i_clear_overflow = 1'b1;
    tick();
    chk("ovf_clear", 64'(o_overflow), 64'(0));
    push(0, 8'hEE, 0);
    i_clear_overflow = 1'b1;
    tick();
    chk("ovf_set_wins", 64'(o_overflow), 64'(1));
    i_clear_overflow = 1'b1;
    tick();
    chk("ovf_clear2", 64'(o_overflow), 64'(0));

    // Fill remaining columns, then push into full column 0 on the first pop
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int c = 1; c < AWID; c++) push(c, 8'($urandom), 0);
    end
    tick(); start_tile(4);
    tick(); push(0, 8'h5A, 1);
    tick();
    chk("fullpop_no_ovf", 64'(o_overflow), 64'(0));
    chk("fullpop_level", 64'(o_fifo_level_max), 64'(DEP));
    wait_done("fullpop_done", 40);
    chk("carry_level", 64'(o_fifo_level_max), 64'(1));

    // Randomized tiles with skewed pushes, random ready and carry-over
    rnd_ready = 1;
    for (int it = 0; it < 14; it++) begin
      maxsz = 0;
      for (int c = 0; c < AWID; c++) if (colq[c].size() > maxsz) maxsz = colq[c].size();
      r = (it == 13) ? maxsz : maxsz + int'($urandom % 2);
      if (r == 0) r = 1;
      for (int c = 0; c < AWID; c++)
        q[c] = r - colq[c].size() + ((it == 13) ? 0 : int'($urandom % 2));
      tick(); start_tile(r);
      n = 0;
      pend = 1;
      while ((pend || !done_seen) && n < 300) begin
        tick();
        pend = 0;
        for (int c = 0; c < AWID; c++) begin
          if (q[c] > 0 && ($urandom % 2) == 1) begin
            push(c, 8'($urandom), 0);
            q[c]--;
          end
          if (q[c] > 0) pend = 1;
        end
        n++;
      end
      chk("rand_done", 64'(done_seen), 64'(1));
    end
    rnd_ready = 0;
    row_if.row_ready = 1'b1;
    tick();
    chk("rand_drained_level", 64'(o_fifo_level_max), 64'(0));

    // Reset in the middle of a tile after two rows
    tick(); start_tile(4);
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int c = 0; c < AWID; c++) push(c, 8'(c*16 + 8 + k), 0);
    end
    n = 0;
    while (tile_acc < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("midreset_rows", 64'(tile_acc), 64'(2));
    rstn = 1'b0;
    for (int c = 0; c < AWID; c++) colq[c].delete();
    #1;
    chk_all_zero("midreset");
    tick();
    rstn = 1'b1;

    // Zero-row tile: done without any row
    done_skip = 1;
    tick(); start_tile(0);
    tick();
    chk("zero_done", 64'(o_done), 64'(1));
    chk("zero_no_row", 64'(row_if.row_valid), 64'(0));
    chk("zero_idle", 64'(o_busy), 64'(0));
    chk("zero_level", 64'(o_fifo_level_max), 64'(0));
    tick();
    chk("zero_done_once", 64'(o_done), 64'(0));
    done_skip = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aw_row_collector.md
Name: aw_row_collector

Overview:
- Receiving end of the per-column AW output streams leaving the PE array buffer columns. Those streams are data+valid only, with no backpressure, and are skewed in time across columns.
- Each column is buffered in its own FIFO to deskew it. Once every column holds an element, one element is popped from each and emitted as one packed row word on a valid/ready stream to the write-back DMA.
- Rows are counted per tile. The last row of a tile is marked, and done is signalled after it is accepted.

Parameters:
ARRAY_WIDTH, 16, number of columns/lanes
QSIZE, 8, bits per AW element
DEPTH, 32, per-column FIFO depth in elements (power of 2, >=2)
ROWW, 16, width of the tile row counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
aw_cb_data[0:ARRAY_WIDTH-1]  in  QSIZE each  per-column AW element
aw_cb_valid[0:ARRAY_WIDTH-1]  in  1 each  per-column element strobe (no ready)
i_start  in  1  pulse: begin a tile; latches i_tile_rows
i_tile_rows  in  ROWW  rows in the tile
i_clear_overflow  in  1  clears o_overflow
o_row_data  out  ARRAY_WIDTH*QSIZE  packed row; column c at bits [c*QSIZE +: QSIZE]
o_row_valid  out  1  row word valid
i_row_ready  in  1  downstream accept
o_row_last  out  1  qualifies the final row of the tile
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse at tile completion
o_overflow  out  1  sticky: element dropped on a full FIFO
o_fifo_level_max  out  $clog2(DEPTH)+1  current max occupancy across FIFOs (debug)

Behaviour:
- Reset (async, rstn=0):
  - All FIFOs are emptied and the state is IDLE.
  - Row counter is 0.
  - o_row_valid=0, o_row_last=0, o_busy=0, o_done=0, o_overflow=0, o_row_data=0, o_fifo_level_max=0.
  - Reset mid-tile discards all buffered data; no done pulse is produced.
- Push:
  - Every cycle, in any state, a column with aw_cb_valid=1 writes aw_cb_data into its FIFO.
  - If the FIFO is full and it is not popped the same cycle, the element is dropped and o_overflow is set on the next edge.
  - Push into a full FIFO in the same cycle as a pop is accepted, and occupancy stays at DEPTH.
- Overflow flag:
  - o_overflow is cleared only by i_clear_overflow or reset.
  - A set and a clear in the same cycle leave it set (set wins).
- Row formation:
  - allne is asserted when all FIFOs are non-empty, evaluated on registered occupancy.
  - In RUN, the output register loads when allne=1 and the register is empty (o_row_valid=0) or being drained (i_row_ready=1). On load, one element is popped from every FIFO simultaneously.
  - In IDLE no pop occurs; data accumulates.
- Latency and throughput:
  - The last needed column element is sampled on edge E; o_row_valid is high after edge E+1.
  - With i_row_ready held high, sustained throughput is one row per cycle.
- Output handshake:
  - o_row_data, o_row_last and o_row_valid are registered.
  - Once valid is asserted, data and last are held stable until the cycle with i_row_ready=1.
  - o_row_valid drops on the next edge unless a new row loads.
- State machine:
  - IDLE: on i_start, latch i_tile_rows into rows_left.
    - If i_tile_rows=0, pulse o_done on the next cycle and stay IDLE.
    - Otherwise go to RUN.
  - RUN: o_busy=1. Each row load decrements rows_left; the load that takes rows_left from 1 to 0 sets o_row_last.
    - Once the last row is loaded, no further loads occur in this tile.
    - When the last row is accepted (valid & ready & last), o_done pulses for one cycle on the next edge and the state returns to IDLE.
  - i_start while in RUN is ignored.
- Occupancy and carry-over:
  - Occupancy counters are $clog2(DEPTH)+1 bits, with pointers wrapping modulo DEPTH.
  - Leftover FIFO contents after a tile are retained for the next tile.

Test Plan:
- Aligned input, ARRAY_WIDTH=4, QSIZE=8: all columns push c*16+n for n=0..3, tile_rows=4, ready=1 -> 4 rows on consecutive cycles.
  - Row 0 = 0x30201000, valid 2 cycles after the first push.
  - last on row 3, done the cycle after, no overflow.
- Skew: column c starts c cycles later, tile_rows=3 -> each row emitted only after column 3's element. Lanes stay aligned and rows are 0x30201000, 0x31211101, 0x32221202.
- Backpressure: ready toggled 1,0,0,1 -> data/last held while ready=0; no row lost or duplicated; total 4 rows in order.
- Overflow, DEPTH=4: column 0 pushes 5 elements in IDLE, others none -> o_overflow=1 after the 5th push and FIFO0 holds the first 4. i_clear_overflow then -> 0.
- Full+pop same cycle: FIFO full, a row loads while column 0 pushes -> push accepted, occupancy stays 4, no overflow.
- Reset mid-tile after 2 of 4 rows, then i_start with tile_rows=0 -> all outputs 0, FIFOs empty; done pulses one cycle after start with no row emitted.
